// File: rtl/ctrl_regs.sv
// Serial control-register receiver: decodes framed writes from the two-wire host
// link into a register bank, with optional even parity, write strobes and an error count.
module ctrl_regs #(
  parameter int unsigned         ADDR_W      = 4,
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         PARITY      = 1,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         ctrl_clk_i,
  input  logic                         ctrl_data_i,
  output logic [NUM_REGS*DATA_W-1:0]   ctrl_o,
  output logic [NUM_REGS-1:0]          wr_stb_o,
  output logic                         busy_o,
  output logic [7:0]                   err_cnt_o
);

  localparam int unsigned FRAME_W = ADDR_W + DATA_W + PARITY;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned AW1     = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RECV, ERR} state_e;

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   clk_sync_q, data_sync_q;
  logic                     clk_hist_q, data_hist_q;
  logic [FRAME_W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_REGS-1:0]      wr_stb_d;

  logic                     lnk_clk, lnk_data;
  logic                     start_c, stop_c, bit_c;
  logic [ADDR_W-1:0]        addr_c;
  logic [DATA_W-1:0]        data_c;
  logic                     par_ok_c, addr_ok_c, frame_ok_c;
  logic                     wr_en_c, err_inc_c;

  // Link synchronizers plus one history flop for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_hist_q  <= 1'b0;
      data_hist_q <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ctrl_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ctrl_data_i};
      clk_hist_q  <= clk_sync_q[SYNC_STAGES-1];
      data_hist_q <= data_sync_q[SYNC_STAGES-1];
    end
  end

  assign lnk_clk  = clk_sync_q[SYNC_STAGES-1];
  assign lnk_data = data_sync_q[SYNC_STAGES-1];
  assign start_c  = lnk_clk & data_hist_q & ~lnk_data;
  assign stop_c   = lnk_clk & ~data_hist_q & lnk_data;
  assign bit_c    = lnk_clk & ~clk_hist_q;

  // Bits arrive LSB first and shift in from the top, so the address lands at bit 0
  assign addr_c     = shift_q[ADDR_W-1:0];
  assign data_c     = shift_q[ADDR_W +: DATA_W];
  assign par_ok_c   = (PARITY == 0) ? 1'b1 : ~(^shift_q);
  assign addr_ok_c  = ({1'b0, addr_c} < AW1'(NUM_REGS));
  assign frame_ok_c = (cnt_q == CNT_W'(FRAME_W)) && par_ok_c && addr_ok_c;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Frame decode; START outranks STOP, which outranks BIT
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    wr_en_c   = 1'b0;
    err_inc_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_c) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = RECV;
        end
      end
      RECV: begin
        if (start_c) begin
          err_inc_c = 1'b1;
          shift_d   = '0;
          cnt_d     = '0;
        end else if (stop_c) begin
          wr_en_c   = frame_ok_c;
          err_inc_c = ~frame_ok_c;
          state_d   = IDLE;
        end else if (bit_c) begin
          if (cnt_q == CNT_W'(FRAME_W)) begin
            state_d = ERR;
          end else begin
            shift_d = {lnk_data, shift_q[FRAME_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      ERR: begin
        if (start_c) begin
          err_inc_c = 1'b1;
          shift_d   = '0;
          cnt_d     = '0;
          state_d   = RECV;
        end else if (stop_c) begin
          err_inc_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      wr_stb_d[i] = wr_en_c && (addr_c == ADDR_W'(i));
    end
  end

  // Register bank, strobes, busy flag and saturating error counter
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_o    <= {NUM_REGS{RESET_VAL}};
      wr_stb_o  <= '0;
      busy_o    <= 1'b0;
      err_cnt_o <= 8'd0;
    end else begin
      wr_stb_o <= wr_stb_d;
      busy_o   <= (state_d != IDLE);
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_stb_d[i]) ctrl_o[i*DATA_W +: DATA_W] <= data_c;
      end
      if (err_inc_c && (err_cnt_o != 8'hFF)) err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_ctrl_regs.sv
// Directed bench for ctrl_regs: a default instance and a NUM_REGS=10 instance share
// the link pins; strobe events are checked against a queue of expected writes.
module tb_ctrl_regs;

  localparam int S = 2;   // SYNC_STAGES
  localparam int P = 4;   // link phase length in clk_i periods

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         ctrl_clk_i;
  logic         ctrl_data_i;
  logic [127:0] ctrl_o;
  logic [15:0]  wr_stb_o;
  logic         busy_o;
  logic [7:0]   err_cnt_o;
  logic [79:0]  ctrl10;
  logic [9:0]   stb10;
  logic         busy10;
  logic [7:0]   err10;

  typedef struct {
    int         a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t        q_main[$];
  wr_t        q10[$];
  logic [7:0] exp_bank [16];
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;

  ctrl_regs u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ctrl_clk_i(ctrl_clk_i), .ctrl_data_i(ctrl_data_i),
    .ctrl_o(ctrl_o), .wr_stb_o(wr_stb_o), .busy_o(busy_o), .err_cnt_o(err_cnt_o)
  );

  ctrl_regs #(.NUM_REGS(10)) u_dut10 (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .ctrl_clk_i(ctrl_clk_i), .ctrl_data_i(ctrl_data_i),
    .ctrl_o(ctrl10), .wr_stb_o(stb10), .busy_o(busy10), .err_cnt_o(err10)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Monitors: every strobe must match the oldest expected write, value and latency
  always @(negedge clk_i) begin : mon_main
    wr_t e;
    if (rst_n_i && wr_stb_o != '0) begin
      if (q_main.size() == 0) begin
        check("stb_main_unexpected", 128'(wr_stb_o), 128'(0));
      end else begin
        e = q_main.pop_front();
        check("stb_main", 128'(wr_stb_o), 128'(16'd1 << e.a));
        check("data_main", 128'(ctrl_o[e.a*8 +: 8]), 128'(e.d));
        check("lat_main", 128'(cyc), 128'(e.c));
      end
    end
  end

  always @(negedge clk_i) begin : mon_10
    wr_t e;
    if (rst_n_i && stb10 != '0) begin
      if (q10.size() == 0) begin
        check("stb10_unexpected", 128'(stb10), 128'(0));
      end else begin
        e = q10.pop_front();
        check("stb10", 128'(stb10), 128'(10'd1 << e.a));
        check("data10", 128'(ctrl10[e.a*8 +: 8]), 128'(e.d));
        check("lat10", 128'(cyc), 128'(e.c));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // START: data falls while link clock is high
  task automatic lnk_start();
    ctrl_data_i = 1'b0;
    tick(P);
  endtask

  task automatic lnk_bit(input logic b);
    ctrl_clk_i = 1'b0;
    tick(2);
    ctrl_data_i = b;
    tick(P);
    ctrl_clk_i = 1'b1;
    tick(P);
  endtask

  // STOP: data rises while link clock is high; the last bit sent must be 0
  task automatic lnk_stop(input bit wr_main, input bit wr_10, input int a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    e.c = cyc + S + 1;
    if (wr_main) begin
      q_main.push_back(e);
      exp_bank[a] = d;
    end
    if (wr_10) q10.push_back(e);
    ctrl_data_i = 1'b1;
    tick(P + 2);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) lnk_bit(bits[i]);
  endtask

  function automatic logic [15:0] mk(input logic [3:0] a, input logic [7:0] d, input logic p);
    return {3'b000, p, d, a};
  endfunction

  // Valid write; callers pick address/data of even weight so the parity bit is 0
  task automatic wr(input int a, input logic [7:0] d);
    lnk_start();
    send_bits(mk(4'(a), d, ^{d, 4'(a)}), 13);
    lnk_stop(1'b1, a < 10, a, d);
  endtask

  task automatic bad_par_frame();
    lnk_start();
    send_bits(mk(4'd3, 8'hA4, 1'b0), 13);
    lnk_stop(1'b0, 1'b0, 0, 8'h00);
  endtask

  task automatic check_bank(input string name);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[i*8 +: 8] = exp_bank[i];
    check(name, ctrl_o, f);
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    tick(2);
    for (int i = 0; i < 16; i++) exp_bank[i] = 8'h00;
    ctrl_clk_i  = 1'b1;
    ctrl_data_i = 1'b1;
    tick(2);
    rst_n_i = 1'b1;
    tick(8);
  endtask

  initial begin
    ctrl_clk_i  = 1'b1;
    ctrl_data_i = 1'b1;
    rst_n_i     = 1'b0;
    for (int i = 0; i < 16; i++) exp_bank[i] = 8'h00;
    tick(3);
    check("rst_ctrl", ctrl_o, 128'(0));
    check("rst_stb", 128'(wr_stb_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    check("rst_err", 128'(err_cnt_o), 128'(0));
    check("rst_busy10", 128'(busy10), 128'(0));
    rst_n_i = 1'b1;
    tick(8);

    // Valid write: address 3, data 0xA5
    wr(3, 8'hA5);
    check_bank("bank_a5");
    check("err_a5", 128'(err_cnt_o), 128'(0));

    // Reset in the middle of a frame
    lnk_start();
    send_bits(16'h002D, 6);
    check("busy_mid", 128'(busy_o), 128'(1));
    rst_n_i = 1'b0;
    tick(2);
    check("midrst_ctrl", ctrl_o, 128'(0));
    check("midrst_busy", 128'(busy_o), 128'(0));
    check("midrst_err", 128'(err_cnt_o), 128'(0));
    for (int i = 0; i < 16; i++) exp_bank[i] = 8'h00;
    ctrl_data_i = 1'b1;
    tick(2);
    rst_n_i = 1'b1;
    tick(8);
    wr(0, 8'h5A);
    check_bank("bank_5a");
    check("err_5a", 128'(err_cnt_o), 128'(0));

    // Parity error (addr 3, data 0xA4, parity bit 0 over odd weight)
    bad_par_frame();
    check("err_par", 128'(err_cnt_o), 128'(1));
    check_bank("bank_par");

    // Short frame: 12 bits
    lnk_start();
    send_bits(16'h0123, 12);
    check("busy_12", 128'(busy_o), 128'(1));
    lnk_stop(1'b0, 1'b0, 0, 8'h00);
    check("err_12", 128'(err_cnt_o), 128'(2));
    check("busy_12_done", 128'(busy_o), 128'(0));

    // Long frame: 14 bits, busy held through the overflow until STOP
    lnk_start();
    send_bits(16'h1A53, 14);
    check("busy_14", 128'(busy_o), 128'(1));
    lnk_stop(1'b0, 1'b0, 0, 8'h00);
    check("err_14", 128'(err_cnt_o), 128'(3));
    check("busy_14_done", 128'(busy_o), 128'(0));
    check("err10_14", 128'(err10), 128'(3));
    check_bank("bank_14");

    // Repeated start: 5 bits, then a new START carrying a valid write to 15
    do_reset();
    lnk_start();
    send_bits(16'h0016, 5);
    wr(15, 8'h3C);
    check_bank("bank_rs");
    check("err_rs", 128'(err_cnt_o), 128'(1));
    check("err10_rs", 128'(err10), 128'(2));

    // Address beyond NUM_REGS=10 on the second instance
    do_reset();
    wr(12, 8'h66);
    check_bank("bank_a12");
    check("err_a12", 128'(err_cnt_o), 128'(0));
    check("err10_a12", 128'(err10), 128'(1));
    check("ctrl10_a12", 128'(ctrl10), 128'(0));

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      bad_par_frame();
      if (i == 253) begin
        check("err_254", 128'(err_cnt_o), 128'(254));
        check("err10_255", 128'(err10), 128'(255));
      end
    end
    check("err_sat", 128'(err_cnt_o), 128'(8'hFF));
    check("err10_sat", 128'(err10), 128'(8'hFF));
    wr(1, 8'h70);
    check_bank("bank_sat");
    check("err_sat_after", 128'(err_cnt_o), 128'(8'hFF));
    check("busy_end", 128'(busy_o), 128'(0));

    tick(10);
    check("q_main_empty", 128'(q_main.size()), 128'(0));
    check("q10_empty", 128'(q10.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
